// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select codes and the multiplier controller state encoding.
// Used by alu_mul_seq (build option MUL_EARLY_TERM_EN) and the execute-stage ALU.
package alu_pkg;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SRL = 3'b100;
    localparam logic [2:0] ALU_OP_SLL = 3'b101;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_XOR = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHR  = 3'd2,
        SHL  = 3'd3,
        DONE = 3'd4
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result handshake plus ALU operand bus for the sequential multiplier.
// slave = multiplier controller side; master = execute stage (requester and ALU).
interface alu_mul_seq_if #(
    parameter int unsigned Bus_Width = 16
);
    logic                 start;
    logic [Bus_Width-1:0] op_a;
    logic [Bus_Width-1:0] op_b;
    logic                 busy;
    logic                 done;
    logic [Bus_Width-1:0] product;
    logic                 ovf;
    logic [Bus_Width-1:0] alu_a;
    logic [Bus_Width-1:0] alu_b;
    logic [2:0]           alu_sel;
    logic [Bus_Width-1:0] alu_result;
    logic                 alu_zero;

    modport slave (
        input  start, op_a, op_b, alu_result, alu_zero,
        output busy, done, product, ovf, alu_a, alu_b, alu_sel
    );

    modport master (
        output start, op_a, op_b, alu_result, alu_zero,
        input  busy, done, product, ovf, alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared execute-stage ALU
// (ADD, SRL, SLL and the Zero flag). Product is the low Bus_Width bits plus a sticky
// overflow flag. Build option MUL_EARLY_TERM_EN: when defined, the sequence ends as soon
// as the remaining multiplier is zero; otherwise it always runs Bus_Width SHR steps.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned Bus_Width = 16
) (
    input logic          clk,
    input logic          rst,
    alu_mul_seq_if.slave bus
);

`ifndef MUL_EARLY_TERM_EN
    localparam int unsigned CntW = $clog2(Bus_Width + 1);
    logic [CntW-1:0] r_cnt;
`endif

    mul_state_e           r_state;
    mul_state_e           w_state_d;
    logic [Bus_Width-1:0] r_acc;
    logic [Bus_Width-1:0] r_mcand;
    logic [Bus_Width-1:0] r_mplier;
    logic [Bus_Width-1:0] r_product;
    logic                 r_ovf;
    logic [Bus_Width-1:0] w_alu_a;
    logic [Bus_Width-1:0] w_alu_b;
    logic [2:0]           w_alu_sel;
    logic                 w_last_shr;

    // Decide whether the current SHR is the final step of the sequence.
    always_comb begin
`ifdef MUL_EARLY_TERM_EN
        w_last_shr = bus.alu_zero;
`else
        w_last_shr = (r_cnt == CntW'(Bus_Width - 1));
`endif
    end

    // Next-state and ALU operand/op-select decode.
    always_comb begin
        w_state_d = r_state;
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_alu_sel = ALU_OP_AND;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_d = bus.op_b[0] ? ADD : SHR;
`ifdef MUL_EARLY_TERM_EN
                    if (bus.op_b == '0) w_state_d = DONE;
`endif
                end
            end
            ADD: begin
                w_alu_a   = r_acc;
                w_alu_b   = r_mcand;
                w_alu_sel = ALU_OP_ADD;
                w_state_d = SHR;
            end
            SHR: begin
                w_alu_a   = r_mplier;
                w_alu_b   = Bus_Width'(1);
                w_alu_sel = ALU_OP_SRL;
                w_state_d = w_last_shr ? DONE : SHL;
            end
            SHL: begin
                w_alu_a   = r_mcand;
                w_alu_b   = Bus_Width'(1);
                w_alu_sel = ALU_OP_SLL;
                // r_mplier already holds the shifted value, so bit 0 is the next bit
                w_state_d = r_mplier[0] ? ADD : SHR;
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_d;
    end

    // Datapath registers, written back from the ALU result of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_ovf     <= 1'b0;
`ifndef MUL_EARLY_TERM_EN
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mcand  <= bus.op_a;
                        r_mplier <= bus.op_b;
                        r_acc    <= '0;
                        r_ovf    <= 1'b0;
`ifndef MUL_EARLY_TERM_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                ADD: begin
                    r_acc <= bus.alu_result;
                    // Wrapped sum is smaller than an addend exactly on carry-out
                    r_ovf <= r_ovf | (bus.alu_result < r_acc);
                end
                SHR: begin
                    r_mplier <= bus.alu_result;
`ifndef MUL_EARLY_TERM_EN
                    r_cnt    <= r_cnt + CntW'(1);
`endif
                end
                SHL: begin
                    r_mcand <= bus.alu_result;
                    // A lost MSB only matters if a multiplier bit is still left to use it
                    r_ovf   <= r_ovf | (r_mcand[Bus_Width-1] & (r_mplier != '0));
                end
                DONE:    r_product <= r_acc;
                default: ;
            endcase
        end
    end

    // Outputs; product follows acc during DONE and holds the registered copy afterwards.
    always_comb begin
        bus.busy    = (r_state == ADD) || (r_state == SHR) || (r_state == SHL);
        bus.done    = (r_state == DONE);
        bus.product = (r_state == DONE) ? r_acc : r_product;
        bus.ovf     = r_ovf;
        bus.alu_a   = w_alu_a;
        bus.alu_b   = w_alu_b;
        bus.alu_sel = w_alu_sel;
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the execute-stage ALU, then checks product, overflow,
// latency and per-operation step counts against a shift-and-add count model.
module tb_alu_mul_seq;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mul_seq_if #(.Bus_Width(W)) bus ();

    alu_mul_seq #(.Bus_Width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU seen by the controller.
    always_comb begin
        logic [W-1:0] res;
        res = '0;
        case (bus.alu_sel)
            3'b000:  res = bus.alu_a & bus.alu_b;
            3'b001:  res = bus.alu_a | bus.alu_b;
            3'b010:  res = bus.alu_a + bus.alu_b;
            3'b100:  res = bus.alu_a >> bus.alu_b;
            3'b101:  res = bus.alu_a << bus.alu_b;
            3'b110:  res = bus.alu_a - bus.alu_b;
            3'b111:  res = bus.alu_a ^ bus.alu_b;
            default: res = '0;
        endcase
        bus.alu_result = res;
        bus.alu_zero   = (res == '0);
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] sel_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiplication from IDLE; leaves the bench one cycle after done.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int lat;
        int last;
        int n_add;
        int n_shr;
        int n_shl;
        logic [31:0] full;
        logic [W-1:0] prod_seen;
        sel_log.delete();
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            if (bus.busy) sel_log.push_back(bus.alu_sel);
            @(posedge clk); #1;
            lat++;
        end
        // Model: one SHR per multiplier bit up to the last one processed, a SHL between
        // consecutive SHRs, and one ADD per set multiplier bit.
        full = 32'(a) * 32'(b);
`ifdef MUL_EARLY_TERM_EN
        last = -1;
        for (int i = 0; i < int'(W); i++) if (b[i]) last = i;
`else
        last = int'(W) - 1;
`endif
        n_add = $countones(b);
        n_shr = last + 1;
        n_shl = (last > 0) ? last : 0;
        prod_seen = bus.product;
        check_eq({tag, " done"}, 32'(bus.done), 32'd1);
        check_eq({tag, " latency"}, 32'(lat), 32'(n_add + n_shr + n_shl + 1));
        check_eq({tag, " product"}, 32'(prod_seen), 32'(full[W-1:0]));
        check_eq({tag, " ovf"}, 32'(bus.ovf), 32'((full >> W) != 0));
        begin
            int c_add = 0;
            int c_shr = 0;
            int c_shl = 0;
            foreach (sel_log[i]) begin
                if (sel_log[i] == 3'b010) c_add++;
                if (sel_log[i] == 3'b100) c_shr++;
                if (sel_log[i] == 3'b101) c_shl++;
            end
            check_eq({tag, " n_add"}, 32'(c_add), 32'(n_add));
            check_eq({tag, " n_shr"}, 32'(c_shr), 32'(n_shr));
            check_eq({tag, " n_shl"}, 32'(c_shl), 32'(n_shl));
        end
        @(posedge clk); #1;
        check_eq({tag, " done pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, " held"}, 32'(bus.product), 32'(full[W-1:0]));
    endtask

    initial begin
        int n_done;
        int waited;
        logic [W-1:0] prod_at_done;
        logic [2:0] exp_sel[7];
        exp_sel = '{3'b010, 3'b100, 3'b101, 3'b100, 3'b101, 3'b010, 3'b100};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy", 32'(bus.busy), 32'd0);
        check_eq("reset done", 32'(bus.done), 32'd0);
        check_eq("reset product", 32'(bus.product), 32'd0);
        check_eq("reset ovf", 32'(bus.ovf), 32'd0);
        check_eq("reset alu", {bus.alu_a, bus.alu_b[12:0], bus.alu_sel}, 32'd0);
        rst = 1'b0;

        run_mul(16'd3, 16'd5, "3x5");
        for (int i = 0; i < 7; i++) check_eq("3x5 sel seq", 32'(sel_log[i]), 32'(exp_sel[i]));

        run_mul(16'h1234, 16'h0000, "x0");
`ifdef MUL_EARLY_TERM_EN
        check_eq("x0 busy never", 32'(sel_log.size()), 32'd0);
`endif
        run_mul(16'h8000, 16'd2, "shl ovf");
        run_mul(16'hFFFF, 16'hFFFF, "all ones");
        run_mul(16'd3, 16'd1, "3x1");

        // Start pulses while busy must be dropped.
        bus.op_a  = 16'd3;
        bus.op_b  = 16'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        n_done       = 0;
        prod_at_done = '0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                n_done++;
                prod_at_done = bus.product;
            end
            bus.start = (c == 2) || (c == 5);
            if (bus.start) begin
                bus.op_a = 16'd7;
                bus.op_b = 16'd9;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check_eq("ignore start n_done", 32'(n_done), 32'd1);
        check_eq("ignore start product", 32'(prod_at_done), 32'd15);
        run_mul(16'd11, 16'd13, "after ignore");

        // Reset during SHL aborts with no done.
        bus.op_a  = 16'd3;
        bus.op_b  = 16'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waited    = 0;
        while (bus.alu_sel != 3'b101 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("reach SHL", 32'(bus.alu_sel), 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort busy", 32'(bus.busy), 32'd0);
        check_eq("abort done", 32'(bus.done), 32'd0);
        check_eq("abort product", 32'(bus.product), 32'd0);
        check_eq("abort ovf", 32'(bus.ovf), 32'd0);
        check_eq("abort alu", {bus.alu_a, bus.alu_b[12:0], bus.alu_sel}, 32'd0);
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done || bus.busy) n_done++;
            @(posedge clk); #1;
        end
        check_eq("abort stays idle", 32'(n_done), 32'd0);
        run_mul(16'd7, 16'd9, "7x9");

        // Random operands, with multipliers biased toward short and sparse values.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 3))
                0: b = b & W'(16'h000F);
                1: b = b & W'($urandom);
                2: a = a | W'(16'h8000);
                default: ;
            endcase
            run_mul(a, b, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
